shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Multi-cycle controller that sequences the single-step 16-bit shifter (codes 00 pass, 01 left-1, 10 logical right-1, 11 arithmetic right-1) to perform shifts of 0..2^A-1 bit positions.
- Latches an operand, drives the shifter's shift code and B input from an internal accumulator, and feeds the shifter output back once per cycle.
- Raises a one-cycle done pulse when the result is ready.
- Sits between the datapath control FSM and the shifter; the shifter instance remains external.

Parameters:
- n, 16, datapath width (operand, accumulator, shifter B/out).
- m, 2, shift-code width; matches the shifter's shift input.
- A, 4, shift-amount width; maximum amount is 2^A-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  m  shifter code to apply at every step (00/01/10/11).
- amount  input  A  number of single-bit steps.
- operand  input  n  value to be shifted.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  n  final value; held until the next accepted start or reset.
- sh_shift  output  m  to shifter shift input.
- sh_b  output  n  to shifter b input; always equals the accumulator.
- sh_in  input  n  from shifter shift_out.

Behaviour:
- Reset, synchronous, active-high, at clk edge. All outputs are low and all internal state is cleared:
  - state=IDLE, acc=0, count=0, op_r=00.
  - busy=0, done=0, result=0, sh_shift=00, sh_b=0.
- State machine: IDLE, SHIFT, DONE. The state register is 2 bits; the unused encoding goes to IDLE on the next edge.
- IDLE, start=1 at an edge:
  - Latch acc<=operand, op_r<=op, count<=amount.
  - If amount==0 or op==00, go to DONE; otherwise go to SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT:
  - sh_shift=op_r, sh_b=acc (combinational).
  - Each edge: acc<=sh_in, count<=count-1.
  - When count==1 at the edge, go to DONE.
  - Exactly `amount` shift cycles occur.
- DONE:
  - done=1, busy=1, result=acc (combinational from acc in this cycle; registered into result at the edge).
  - Next edge: result<=acc, state<=IDLE.
  - result holds its value in IDLE.
- sh_shift=00 in IDLE and DONE, so the shifter passes the operand through.
- Latency, with start sampled at edge 0:
  - done is high in cycle amount+1 (cycle 1 when amount==0 or op==00).
  - busy is high in cycles 1..amount+1.
  - A new start is accepted no earlier than edge amount+2.
- start is ignored while busy; op, amount and operand are don't-care outside the accept edge.
- Back-to-back: start held high continuously is re-accepted at the first IDLE edge, giving one idle cycle between jobs.
- reset mid-operation (SHIFT or DONE): abort immediately, with no done pulse and result=0.
- Width rules:
  - Left shifts fill the LSB with 0.
  - Logical right shifts fill the MSB with 0.
  - Arithmetic right shifts replicate bit n-1 at every step, so the sign is saturated for large amounts.
  - Bits shifted out are discarded; there is no carry or overflow flag.

Test Plan:
- Left shift: reset then start, op=01, amount=4, operand=16'h0001 -> sh_shift=01 for cycles 1-4, done=1 in cycle 5, result=16'h0010, busy low in cycle 6.
- Arithmetic right: op=11, amount=3, operand=16'h8000 -> result=16'hF000 at done (cycle 4).
- Logical right, maximum amount: op=10, amount=15, operand=16'h8000 -> result=16'h0001, done in cycle 16.
- Zero-step cases:
  - op=01, amount=0, operand=16'hABCD -> done in cycle 1, result=16'hABCD, sh_shift never 01.
  - op=00, amount=7, operand=16'h1234 -> done in cycle 1, result=16'h1234.
- start while busy:
  - op=01, amount=2, operand=16'h0003 -> result=16'h000C.
  - A start with operand=16'hFFFF pulsed in cycle 1 is ignored.
  - start held high from cycle 3 is accepted at the edge ending cycle 4.
- Reset mid-operation: op=01, amount=8, reset in cycle 3 -> next cycle busy=0, done=0, result=0, sh_shift=00; a following job op=01, amount=1, operand=16'h4000 gives result=16'h8000.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: drives an external single-step shifter once per
// cycle until the requested number of bit positions has been applied.
module shift_seq_ctrl #(
    parameter int n = 16,
    parameter int m = 2,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [m-1:0] op,
    input  logic [A-1:0] amount,
    input  logic [n-1:0] operand,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic [m-1:0] sh_shift,
    output logic [n-1:0] sh_b,
    input  logic [n-1:0] sh_in
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t       state;
    logic [n-1:0] acc;
    logic [n-1:0] result_r;
    logic [A-1:0] count;
    logic [m-1:0] op_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            op_r     <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= operand;
                        op_r  <= op;
                        count <= amount;
                        // A pass code or a zero amount needs no shifter cycles at all.
                        state <= (amount == '0 || op == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= sh_in;
                    count <= count - A'(1);
                    if (count == A'(1))
                        state <= DONE;
                end
                DONE: begin
                    result_r <= acc;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In DONE the result is shown straight from acc so it is valid alongside done.
    assign busy     = (state == SHIFT) || (state == DONE);
    assign done     = (state == DONE);
    assign result   = (state == DONE) ? acc : result_r;
    assign sh_shift = (state == SHIFT) ? op_r : '0;
    assign sh_b     = acc;

endmodule
